trig_input_cond: RTL and testbench
==================================

# trig_input_cond

Input conditioning stage directly upstream of the trigger firing state machine. It synchronizes the asynchronous coax discriminator inputs, rejects glitches shorter than a programmable width, and forms a single-cycle trigger request. The request is an OR or coincidence of the channels, with per-channel masking and prescaling. It also keeps per-channel hit-rate counters latched once per gate period for monitoring and LED/readout use.

## Interface
- NCH, 2: number of coax input channels (2..8)
- MINW, 2: minimum consecutive synchronized-high cycles for a valid hit (1..15)
- WINDOW, 4: coincidence window length in cycles (1..255)
- GATE, 200000000: rate gate period in cycles (1 s at 200 MHz)
- CNTW, 32: rate counter width
- clk  in  1  system clock (200 MHz from PLL)
- nrst  in  1  reset, synchronous, active-low
- coax_in  in  NCH  raw asynchronous discriminator inputs
- mode  in  2  0=OR, 1=AND (all unmasked channels within WINDOW), 2=ch0 only, 3=ch1 only
- mask  in  NCH  1=channel participates in trigger
- prescale  in  8  emit one trig_req per prescale+1 qualifying triggers
- veto  in  1  downstream busy/inhibit; suppresses trig_req
- ch_hit  out  NCH  one-cycle pulse per qualified hit (independent of mask)
- trig_req  out  1  one-cycle trigger request to firing stage
- rate_out  out  NCH*CNTW  latched hit counts of the last gate; ch i at [i*CNTW +: CNTW]
- rate_valid  out  1  one-cycle pulse when rate_out updates
- vetoed_cnt  out  16  saturating count of triggers suppressed by veto since reset

## Operation
- Reset (nrst=0 at a clk edge): sync flops, run counters, windows, prescale counter, gate counter, and hit counters clear. All outputs go to 0.
- Synchronizer: two flops per channel (s1, s2). No logic on s1.
- Glitch filter, per channel:
  - The run counter increments while s2=1 and saturates at MINW. It clears when s2=0.
  - ch_hit pulses once, in the cycle after the run counter reaches MINW.
  - The channel re-arms only after s2 returns to 0. A long pulse gives exactly one hit.
- Window, per channel:
  - A hit loads win[i]=WINDOW. Otherwise win[i] decrements toward 0.
  - The channel is open while win[i]!=0 or a hit occurs this cycle.
- Trigger condition, evaluated each cycle:
  - OR: any unmasked ch_hit.
  - AND: all unmasked channels open. On a match, all windows clear, so one coincidence yields one trigger.
  - Modes 2/3: ch_hit[0] / ch_hit[1]. The mask bit still applies.
  - mask=0 means no trigger in any mode.
- Prescale:
  - Each qualifying trigger increments psc.
  - When psc>=prescale: psc clears and the trigger is emitted. prescale=0 means every trigger is emitted.
  - Lowering prescale below psc causes emission on the next qualifying trigger.
- Veto: an emitted trigger with veto=1 does not assert trig_req. vetoed_cnt increments and saturates at 0xFFFF. psc still clears.
- Rate counters:
  - Per-channel hit counter increments on ch_hit and saturates at 2^CNTW-1.
  - Gate counter runs 0..GATE-1. On wrap, counters copy to rate_out, rate_valid pulses, and counters clear.
  - A hit in the wrap cycle counts into the new interval as 1.
- mode, mask, and prescale are sampled every cycle with no shadowing. A change affects triggers evaluated from the next cycle.

## Timing
- Input high first sampled at edge N: s1=1 after N, s2=1 after N+1.
- ch_hit is high in the cycle after edge N+MINW+1.
- trig_req (OR, prescale 0, veto 0) is high in the cycle after edge N+MINW+2. Total latency is MINW+3 edges.
- Pulse widths:
  - Input pulses of fewer than MINW sampled-high cycles produce nothing.
  - Exactly MINW cycles produces one hit.
- AND mode window: hits on two channels separated by d cycles trigger iff d<=WINDOW. d=0 (same cycle) triggers.
- Back-to-back: trig_req may assert on consecutive cycles if the conditions qualify. The downstream dead time handles rejection.
- Reset mid-pulse: the pulse is discarded. A still-high input after reset release needs MINW full sampled cycles to qualify.
- rate_valid is high for the cycle after gate-counter edge GATE-1. The first pulse occurs GATE cycles after reset release.

## Test plan
- OR, MINW=2, prescale=0: 3-cycle pulse on ch0 -> one ch_hit[0] and one trig_req, trig_req 5 edges after first sample. 1-cycle pulse -> nothing.
- AND, WINDOW=4: ch0 hit, then ch1 hit 4 cycles later -> one trig_req. Repeat at 5 cycles -> none. Simultaneous hits -> exactly one trig_req.
- mask=2'b01 in AND mode: ch0 hit alone -> trig_req. mask=0: hits on both channels -> no trig_req, ch_hit still pulses.
- prescale=3, 10 OR triggers -> trig_req on triggers 4 and 8 only. veto=1 on trigger 8 -> no pulse, vetoed_cnt=1.
- GATE=100 (test override): 7 ch0 hits in gate 1, hit in the wrap cycle -> rate_out ch0=7, rate_valid once at cycle 100, next interval starts at 1.
- Hold coax_in high across nrst pulse -> no hit during reset. Outputs read 0. One hit MINW+2 edges after release.

Source files
------------

// File: rtl/trig_input_cond_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trig_input_cond_if : bus between trigger input conditioning and host |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface trig_input_cond_if #(
   parameter int NCH  = 2,
   parameter int CNTW = 32
);
   logic [NCH-1:0]      coax_in;
   logic [1:0]          mode;
   logic [NCH-1:0]      mask;
   logic [7:0]          prescale;
   logic                veto;
   logic [NCH-1:0]      ch_hit;
   logic                trig_req;
   logic [NCH*CNTW-1:0] rate_out;
   logic                rate_valid;
   logic [15:0]         vetoed_cnt;

   modport master (
      output coax_in, mode, mask, prescale, veto,
      input  ch_hit, trig_req, rate_out, rate_valid, vetoed_cnt
   );

   modport slave (
      input  coax_in, mode, mask, prescale, veto,
      output ch_hit, trig_req, rate_out, rate_valid, vetoed_cnt
   );
endinterface
`default_nettype wire

// File: rtl/trig_input_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trig_input_cond : sync, glitch filter, OR/AND trigger, rate monitor  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trig_input_cond #(
   parameter int NCH    = 2,
   parameter int MINW   = 2,
   parameter int WINDOW = 4,
   parameter int GATE   = 200000000,
   parameter int CNTW   = 32
) (
   input  wire logic          clk,
   input  wire logic          nrst,
   trig_input_cond_if.slave   bus
);
   localparam int RW = 4;
   localparam int WW = 8;
   localparam int GW = (GATE > 1) ? $clog2(GATE) : 1;
   localparam logic [RW-1:0]   MINW_C    = RW'(MINW);
   localparam logic [RW-1:0]   MINW_M1   = RW'(MINW - 1);
   localparam logic [WW-1:0]   WIN_C     = WW'(WINDOW);
   localparam logic [GW-1:0]   GATE_LAST = GW'(GATE - 1);
   localparam logic [CNTW-1:0] CNT_MAX   = '1;

   logic [NCH-1:0]      s1;
   logic [NCH-1:0]      s2;
   logic [NCH-1:0]      hit;
   logic [NCH-1:0]      open_ch;
   logic [NCH*CNTW-1:0] rate_flat;
   logic [GW-1:0]       gate;
   logic                gate_wrap;
   logic                match;
   logic                and_clear;
   logic                emit;
   logic [7:0]          psc;
   logic                trig_q;
   logic                rv_q;
   logic [15:0]         vcnt;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= bus.coax_in;
         s2 <= s1;
      end
   end

   assign gate_wrap = (gate == GATE_LAST);

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ch
         logic [RW-1:0]   run;
         logic            hit_q;
         logic [WW-1:0]   win;
         logic [CNTW-1:0] cnt;
         logic [CNTW-1:0] latched;

         // run saturates at MINW, so the MINW-1 -> MINW step happens once per pulse
         always_ff @(posedge clk) begin
            if (!nrst) begin
               run   <= '0;
               hit_q <= 1'b0;
            end else begin
               if (s2[i]) begin
                  if (run != MINW_C)
                     run <= run + 1'b1;
               end else begin
                  run <= '0;
               end
               hit_q <= s2[i] && (run == MINW_M1);
            end
         end

         always_ff @(posedge clk) begin
            if (!nrst)
               win <= '0;
            else if (and_clear)
               win <= '0;
            else if (hit_q)
               win <= WIN_C;
            else if (win != '0)
               win <= win - 1'b1;
         end

         // a hit landing in the wrap cycle opens the new interval at 1
         always_ff @(posedge clk) begin
            if (!nrst) begin
               cnt     <= '0;
               latched <= '0;
            end else if (gate_wrap) begin
               latched <= cnt;
               cnt     <= hit_q ? CNTW'(1) : '0;
            end else if (hit_q && (cnt != CNT_MAX)) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign hit[i]                      = hit_q;
         assign open_ch[i]                  = (win != '0) || hit_q;
         assign rate_flat[i*CNTW +: CNTW]   = latched;
      end
   endgenerate

   always_comb begin
      match     = 1'b0;
      and_clear = 1'b0;
      case (bus.mode)
         2'd0: match = |(hit & bus.mask);
         2'd1: begin
            match     = (|bus.mask) && (&(open_ch | ~bus.mask));
            and_clear = match;
         end
         2'd2: match = hit[0] & bus.mask[0];
         default: match = hit[1] & bus.mask[1];
      endcase
   end

   assign emit = match && (psc >= bus.prescale);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         psc    <= '0;
         trig_q <= 1'b0;
         vcnt   <= '0;
      end else begin
         if (match) begin
            if (emit)
               psc <= '0;
            else
               psc <= psc + 8'd1;
         end
         trig_q <= emit && !bus.veto;
         if (emit && bus.veto && (vcnt != 16'hFFFF))
            vcnt <= vcnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         gate <= '0;
         rv_q <= 1'b0;
      end else begin
         gate <= gate_wrap ? '0 : gate + 1'b1;
         rv_q <= gate_wrap;
      end
   end

   assign bus.ch_hit     = hit;
   assign bus.trig_req   = trig_q;
   assign bus.rate_out   = rate_flat;
   assign bus.rate_valid = rv_q;
   assign bus.vetoed_cnt = vcnt;
endmodule
`default_nettype wire

// File: tb/tb_trig_input_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trig_input_cond : directed self-checking bench for trig_input_cond|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_trig_input_cond;
   localparam int NCH    = 2;
   localparam int MINW   = 2;
   localparam int WINDOW = 4;
   localparam int GATE   = 100;
   localparam int CNTW   = 32;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   trig_tot = 0;
   int   hit0_tot = 0;
   int   hit1_tot = 0;

   trig_input_cond_if #(.NCH(NCH), .CNTW(CNTW)) bus ();

   trig_input_cond #(
      .NCH(NCH), .MINW(MINW), .WINDOW(WINDOW), .GATE(GATE), .CNTW(CNTW)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.trig_req)  trig_tot = trig_tot + 1;
      if (bus.ch_hit[0]) hit0_tot = hit0_tot + 1;
      if (bus.ch_hit[1]) hit1_tot = hit1_tot + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulses(input logic [1:0] en, input int d);
      for (int t = 0; t < 25; t++) begin
         bus.coax_in[0] = en[0] && (t < 3);
         bus.coax_in[1] = en[1] && (t >= d) && (t < d + 3);
         tick();
      end
      bus.coax_in = '0;
   endtask

   task automatic test_reset();
      bus.coax_in = '0; bus.mode = 2'd0; bus.mask = 2'b11;
      bus.prescale = 8'd0; bus.veto = 1'b0;
      nrst = 1'b0;
      repeat (3) tick();
      tests++; if (bus.ch_hit !== 2'b00) begin fails++; $display("FAIL reset_ch_hit: got %0h expected 0", bus.ch_hit); end
      tests++; if (bus.trig_req !== 1'b0) begin fails++; $display("FAIL reset_trig_req: got %0h expected 0", bus.trig_req); end
      tests++; if (bus.rate_out !== 64'd0) begin fails++; $display("FAIL reset_rate_out: got %0h expected 0", bus.rate_out); end
      tests++; if (bus.rate_valid !== 1'b0) begin fails++; $display("FAIL reset_rate_valid: got %0h expected 0", bus.rate_valid); end
      tests++; if (bus.vetoed_cnt !== 16'd0) begin fails++; $display("FAIL reset_vetoed_cnt: got %0h expected 0", bus.vetoed_cnt); end
      nrst = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_or_latency();
      int hit_k, trig_k, bt, bh;
      hit_k = -1; trig_k = -1; bt = trig_tot; bh = hit0_tot;
      bus.mode = 2'd0; bus.mask = 2'b11;
      bus.coax_in = 2'b01;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 3) bus.coax_in = 2'b00;
         if (bus.ch_hit[0] && hit_k < 0) hit_k = k;
         if (bus.trig_req && trig_k < 0) trig_k = k;
      end
      tests++; if (hit_k != 4) begin fails++; $display("FAIL or_hit_latency: got %0d expected 4", hit_k); end
      tests++; if (trig_k != 5) begin fails++; $display("FAIL or_trig_latency: got %0d expected 5", trig_k); end
      tests++; if (hit0_tot - bh != 1) begin fails++; $display("FAIL or_hit_count: got %0d expected 1", hit0_tot - bh); end
      tests++; if (trig_tot - bt != 1) begin fails++; $display("FAIL or_trig_count: got %0d expected 1", trig_tot - bt); end
   endtask

   task automatic test_glitch();
      int bt, bh;
      bt = trig_tot; bh = hit0_tot;
      bus.coax_in = 2'b01; tick(); bus.coax_in = 2'b00;
      repeat (10) tick();
      tests++; if (hit0_tot - bh != 0) begin fails++; $display("FAIL glitch_hit: got %0d expected 0", hit0_tot - bh); end
      tests++; if (trig_tot - bt != 0) begin fails++; $display("FAIL glitch_trig: got %0d expected 0", trig_tot - bt); end
      bh = hit0_tot;
      bus.coax_in = 2'b01; tick(); tick(); bus.coax_in = 2'b00;
      repeat (10) tick();
      tests++; if (hit0_tot - bh != 1) begin fails++; $display("FAIL minw_pulse_hit: got %0d expected 1", hit0_tot - bh); end
   endtask

   task automatic test_and_window();
      int bt, bh;
      bus.mode = 2'd1; bus.mask = 2'b11;
      bt = trig_tot; pulses(2'b11, 4);
      tests++; if (trig_tot - bt != 1) begin fails++; $display("FAIL and_d4: got %0d expected 1", trig_tot - bt); end
      bt = trig_tot; pulses(2'b11, 5);
      tests++; if (trig_tot - bt != 0) begin fails++; $display("FAIL and_d5: got %0d expected 0", trig_tot - bt); end
      bt = trig_tot; bh = hit1_tot; pulses(2'b11, 0);
      tests++; if (trig_tot - bt != 1) begin fails++; $display("FAIL and_d0: got %0d expected 1", trig_tot - bt); end
      tests++; if (hit1_tot - bh != 1) begin fails++; $display("FAIL and_d0_hit1: got %0d expected 1", hit1_tot - bh); end
   endtask

   task automatic test_mask();
      int bt, b0, b1;
      bus.mode = 2'd1; bus.mask = 2'b01;
      bt = trig_tot; pulses(2'b01, 0);
      tests++; if (trig_tot - bt != 1) begin fails++; $display("FAIL mask01_and_ch0: got %0d expected 1", trig_tot - bt); end
      bt = trig_tot; pulses(2'b10, 0);
      tests++; if (trig_tot - bt != 0) begin fails++; $display("FAIL mask01_and_ch1: got %0d expected 0", trig_tot - bt); end
      bus.mask = 2'b00;
      bt = trig_tot; b0 = hit0_tot; b1 = hit1_tot; pulses(2'b11, 0);
      tests++; if (trig_tot - bt != 0) begin fails++; $display("FAIL mask00_trig: got %0d expected 0", trig_tot - bt); end
      tests++; if (hit0_tot - b0 != 1 || hit1_tot - b1 != 1) begin fails++; $display("FAIL mask00_hits: got %0d/%0d expected 1/1", hit0_tot - b0, hit1_tot - b1); end
      bus.mode = 2'd3; bus.mask = 2'b11;
      bt = trig_tot; pulses(2'b01, 0);
      tests++; if (trig_tot - bt != 0) begin fails++; $display("FAIL mode3_ch0: got %0d expected 0", trig_tot - bt); end
      bt = trig_tot; pulses(2'b10, 0);
      tests++; if (trig_tot - bt != 1) begin fails++; $display("FAIL mode3_ch1: got %0d expected 1", trig_tot - bt); end
      bus.mode = 2'd2; bus.mask = 2'b10;
      bt = trig_tot; pulses(2'b01, 0);
      tests++; if (trig_tot - bt != 0) begin fails++; $display("FAIL mode2_masked: got %0d expected 0", trig_tot - bt); end
      bus.mode = 2'd0; bus.mask = 2'b11;
   endtask

   task automatic test_prescale_veto();
      int bt, exp_n;
      bus.mode = 2'd0; bus.mask = 2'b11; bus.prescale = 8'd3;
      for (int j = 1; j <= 12; j++) begin
         bus.veto = (j == 8);
         bt = trig_tot;
         pulses(2'b01, 0);
         exp_n = (j == 4 || j == 12) ? 1 : 0;
         tests++; if (trig_tot - bt != exp_n) begin fails++; $display("FAIL prescale_trig%0d: got %0d expected %0d", j, trig_tot - bt, exp_n); end
      end
      bus.veto = 1'b0;
      tests++; if (bus.vetoed_cnt !== 16'd1) begin fails++; $display("FAIL vetoed_cnt: got %0d expected 1", bus.vetoed_cnt); end
      bus.prescale = 8'd0;
   endtask

   task automatic test_rate();
      int starts [8] = '{5, 15, 25, 35, 45, 55, 65, 96};
      int rv_n, rv_k1, rv_k2;
      logic [31:0] r1, r1b, r2;
      logic hit99;
      rv_n = 0; rv_k1 = -1; rv_k2 = -1; r1 = '1; r1b = '1; r2 = '1; hit99 = 1'b0;
      bus.coax_in = '0;
      nrst = 1'b0; tick(); tick(); nrst = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         bus.coax_in[0] = 1'b0;
         foreach (starts[s]) if (k >= starts[s] && k < starts[s] + 3) bus.coax_in[0] = 1'b1;
         tick();
         if (k == 99) hit99 = bus.ch_hit[0];
         if (bus.rate_valid) begin
            rv_n++;
            if (rv_n == 1) begin rv_k1 = k; r1 = bus.rate_out[31:0]; r1b = bus.rate_out[63:32]; end
            else if (rv_n == 2) begin rv_k2 = k; r2 = bus.rate_out[31:0]; end
         end
      end
      bus.coax_in = '0;
      tests++; if (hit99 !== 1'b1) begin fails++; $display("FAIL rate_wrap_hit: got %0b expected 1", hit99); end
      tests++; if (rv_k1 != 100) begin fails++; $display("FAIL rate_valid_first: got %0d expected 100", rv_k1); end
      tests++; if (r1 !== 32'd7) begin fails++; $display("FAIL rate_ch0_gate1: got %0d expected 7", r1); end
      tests++; if (r1b !== 32'd0) begin fails++; $display("FAIL rate_ch1_gate1: got %0d expected 0", r1b); end
      tests++; if (rv_k2 != 200) begin fails++; $display("FAIL rate_valid_second: got %0d expected 200", rv_k2); end
      tests++; if (r2 !== 32'd1) begin fails++; $display("FAIL rate_ch0_gate2: got %0d expected 1", r2); end
      tests++; if (rv_n != 2) begin fails++; $display("FAIL rate_valid_count: got %0d expected 2", rv_n); end
   endtask

   task automatic test_reset_mid_pulse();
      int bh, hk;
      hk = -1;
      bus.mode = 2'd0; bus.mask = 2'b11;
      bus.coax_in = 2'b11;
      tick(); tick();
      nrst = 1'b0;
      tick();
      bh = hit0_tot;
      tick(); tick();
      tests++; if (hit0_tot - bh != 0) begin fails++; $display("FAIL rst_mid_no_hit: got %0d expected 0", hit0_tot - bh); end
      tests++; if (bus.ch_hit !== 2'b00 || bus.trig_req !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs: got %0h/%0h expected 0/0", bus.ch_hit, bus.trig_req); end
      nrst = 1'b1;
      bh = hit0_tot;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.ch_hit[0] && hk < 0) hk = k;
      end
      bus.coax_in = '0;
      tests++; if (hk != 4) begin fails++; $display("FAIL rst_release_latency: got %0d expected 4", hk); end
      tests++; if (hit0_tot - bh != 1) begin fails++; $display("FAIL rst_release_hits: got %0d expected 1", hit0_tot - bh); end
   endtask

   initial begin
      test_reset();
      test_or_latency();
      test_glitch();
      test_and_window();
      test_mask();
      test_prescale_veto();
      test_rate();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
